rn_axis_pkt_checker: RTL
========================

Name: rn_axis_pkt_checker

Overview:
- In-line AXI-Stream packet checker between the simulation stimulus driver's m_axis output and the RecoNIC RX stream input.
- Passes beats through a 2-entry skid buffer with registered ready.
- Validates framing of each accepted packet: tkeep contiguity, byte count versus tuser_size, tuser_size stability, oversize.
- Keeps saturating statistics counters and sticky error flags for the bench to read at end of test.

Parameters:
AXIS_DATA_WIDTH, 512, stream data width in bits
AXIS_KEEP_WIDTH, 64, tkeep width (AXIS_DATA_WIDTH/8)
USER_SIZE_WIDTH, 16, width of tuser_size (packet length in bytes)
MAX_PKT_BYTES, 9600, byte count above which a packet is flagged oversize

Ports:
axis_clk  in  1  stream clock
axis_rst  in  1  asynchronous active-high reset
s_axis_tdata  in  AXIS_DATA_WIDTH  upstream data
s_axis_tkeep  in  AXIS_KEEP_WIDTH  upstream byte enables
s_axis_tvalid  in  1  upstream valid
s_axis_tlast  in  1  upstream end of packet
s_axis_tuser_size  in  USER_SIZE_WIDTH  packet length in bytes, constant for the whole packet
s_axis_tready  out  1  registered ready to upstream
m_axis_tdata / m_axis_tkeep / m_axis_tvalid / m_axis_tlast / m_axis_tuser_size  out  same widths  downstream copy
m_axis_tready  in  1  downstream ready
clr_stats  in  1  synchronous clear of all counters and sticky flags
pkt_done  out  1  one-cycle pulse when a tlast beat is accepted on s_axis
pkt_done_bytes  out  USER_SIZE_WIDTH  counted bytes of that packet; valid with pkt_done
stat_pkt_cnt  out  32  packets accepted
stat_byte_cnt  out  48  bytes accepted (sum of tkeep popcounts)
stat_len_err_cnt  out  16  packets whose counted bytes differ from tuser_size
stat_keep_err_cnt  out  16  beats with an illegal tkeep
err_sticky  out  4  [0] length mismatch, [1] keep error, [2] tuser_size changed mid-packet, [3] oversize

Behaviour:
- Reset (axis_rst high, async): skid empty; s_axis_tready=0, then 1 on the first clock after deassertion. All m_axis_* outputs 0. Counters, err_sticky, pkt_done and pkt_done_bytes 0. FSM=IDLE. A packet in flight is discarded and not counted.
- Accept: s_axis_tvalid & s_axis_tready.
- Skid buffer: 2 entries, strict order. s_axis_tready is registered and equals "fewer than 2 entries occupied after this cycle".
- Latency: accepted beat appears on m_axis the next cycle when the buffer was empty. Zero bubbles at full throughput with m_axis_tready=1.
- m_axis_* hold stable while m_axis_tvalid=1 and m_axis_tready=0.
- The checker observes accepted s_axis beats only; checking never alters forwarded data.
- Per-beat bytes = popcount(tkeep).
- Legal tkeep on a non-last beat: all ones.
- Legal tkeep on a last beat: nonzero and contiguous from bit 0 (2^n-1, n=1..KEEP_WIDTH).
- Each illegal beat increments stat_keep_err_cnt and sets err_sticky[1].
- FSM IDLE: an accepted beat latches tuser_size into size_reg, loads acc = beat bytes, and goes to IN_PKT if tlast=0.
- FSM IN_PKT: acc += beat bytes. If tuser_size != size_reg, set err_sticky[2] (once per packet is sufficient, the flag is sticky).
- On any tlast beat (including a single-beat packet from IDLE):
  - pulse pkt_done next cycle, with pkt_done_bytes = final acc;
  - stat_pkt_cnt += 1; stat_byte_cnt += final acc;
  - if final acc != size_reg (or != tuser_size when a single beat): stat_len_err_cnt += 1 and set err_sticky[0];
  - return to IDLE.
- acc is 1 bit wider than USER_SIZE_WIDTH and saturates at all-ones. If acc exceeds MAX_PKT_BYTES, set err_sticky[3]; the packet is still forwarded.
- All counters saturate at their maximum, with no wrap.
- clr_stats zeroes counters and err_sticky. If an event occurs in the same cycle, the counter takes only that cycle's increment (clear-then-add). clr_stats does not affect the FSM, acc or the skid buffer.
- Simultaneous push and pop on a full buffer is legal: ready stays 0 this cycle; occupancy is unchanged.

Test Plan:
- Reset then a single beat (tkeep all ones, tlast=1, tuser_size=64) with m_axis_tready=1 -> m_axis_tvalid one cycle later with identical data; pkt_done with pkt_done_bytes=64; stat_pkt_cnt=1, stat_byte_cnt=64, err_sticky=0.
- 100-byte packet: beat 1 tkeep all ones, beat 2 tkeep=0x0000000FFFFFFFFF, tlast, tuser_size=100 -> pkt_done_bytes=100, no errors. Repeat with tuser_size=90 -> stat_len_err_cnt=1, err_sticky[0]=1.
- Last beat tkeep=0x0F0F -> stat_keep_err_cnt=1, err_sticky[1]=1; beat still forwarded unchanged.
- 20 back-to-back 3-beat packets; m_axis_tready low for 10 cycles mid-stream -> s_axis_tready drops within 2 accepted beats; output order and data match input exactly; stat_pkt_cnt=20.
- tuser_size changes from 128 to 64 on beat 2 of a packet -> err_sticky[2]=1. A 160-beat packet with MAX_PKT_BYTES=9600 (10240 bytes) -> err_sticky[3]=1.
- Assert axis_rst mid-packet, then send a clean 64-byte packet -> stat_pkt_cnt=1 and no errors. Assert clr_stats in the same cycle as a tlast accept -> stat_pkt_cnt=1 after the clear.

Source files
------------

// File: rtl/rn_axis_pkt_checker.sv
// In-line AXI-Stream framing checker: 2-entry skid buffer with registered ready,
// per-packet length/keep/size checks, saturating stats and sticky error flags.
module rn_axis_pkt_checker #(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = 64,
  parameter int USER_SIZE_WIDTH = 16,
  parameter int MAX_PKT_BYTES   = 9600
) (
  input  logic                       axis_clk,
  input  logic                       axis_rst,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  input  logic [USER_SIZE_WIDTH-1:0] s_axis_tuser_size,
  output logic                       s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  output logic [USER_SIZE_WIDTH-1:0] m_axis_tuser_size,
  input  logic                       m_axis_tready,
  input  logic                       clr_stats,
  output logic                       pkt_done,
  output logic [USER_SIZE_WIDTH-1:0] pkt_done_bytes,
  output logic [31:0]                stat_pkt_cnt,
  output logic [47:0]                stat_byte_cnt,
  output logic [15:0]                stat_len_err_cnt,
  output logic [15:0]                stat_keep_err_cnt,
  output logic [3:0]                 err_sticky
);
  localparam int AW = USER_SIZE_WIDTH + 1;
  localparam int PW = $clog2(AXIS_KEEP_WIDTH + 1);

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] data;
    logic [AXIS_KEEP_WIDTH-1:0] keep;
    logic                       last;
    logic [USER_SIZE_WIDTH-1:0] user;
  } beat_t;

  typedef enum logic {IDLE, IN_PKT} state_t;

  beat_t  in_beat, ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0] cnt_q, cnt_d;
  logic   rdy_q, rdy_d;
  logic   push, pop;

  state_t state_q, state_d;
  logic [USER_SIZE_WIDTH-1:0] size_q, size_d, size_cmp;
  logic [AW-1:0] acc_q, acc_d, acc_new;
  logic [AW:0]   acc_wide;
  logic [PW-1:0] beat_bytes;
  logic          keep_ok;
  logic          done_q, done_d;
  logic [USER_SIZE_WIDTH-1:0] done_bytes_q, done_bytes_d;
  logic [31:0] pkt_q, pkt_d, pkt_base;
  logic [47:0] byte_q, byte_d, byte_base;
  logic [15:0] len_q, len_d, len_base, keep_q, keep_d, keep_base;
  logic [3:0]  sticky_q, sticky_d;
  logic [32:0] pkt_sum;
  logic [48:0] byte_sum;
  logic [16:0] len_sum, keep_sum;

  assign in_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser_size};
  assign push    = s_axis_tvalid & rdy_q;
  assign pop     = (cnt_q != 2'd0) & m_axis_tready;

  // Head entry always drives the output; a push into a full buffer cannot
  // happen because ready already reflects "fewer than 2 after this cycle".
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case (cnt_q)
      2'd0: if (push) begin ent0_d = in_beat; cnt_d = 2'd1; end
      2'd1: begin
        if (push && pop)  ent0_d = in_beat;
        else if (push)    begin ent1_d = in_beat; cnt_d = 2'd2; end
        else if (pop)     cnt_d = 2'd0;
      end
      default: if (pop) begin ent0_d = ent1_q; cnt_d = 2'd1; end
    endcase
    rdy_d = (cnt_d < 2'd2);
  end

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < AXIS_KEEP_WIDTH; i++)
      beat_bytes = beat_bytes + PW'(s_axis_tkeep[i]);
  end

  assign keep_ok = s_axis_tlast
    ? ((s_axis_tkeep != '0) && ((s_axis_tkeep & (s_axis_tkeep + AXIS_KEEP_WIDTH'(1))) == '0))
    : (&s_axis_tkeep);

  assign acc_wide = {1'b0, acc_q} + (AW+1)'(beat_bytes);
  assign acc_new  = (state_q == IDLE) ? AW'(beat_bytes)
                  : (acc_wide[AW] ? {AW{1'b1}} : acc_wide[AW-1:0]);
  assign size_cmp = (state_q == IDLE) ? s_axis_tuser_size : size_q;

  // Clear-then-add: the clear picks the base, this cycle's event adds on top.
  assign pkt_base  = clr_stats ? '0 : pkt_q;
  assign byte_base = clr_stats ? '0 : byte_q;
  assign len_base  = clr_stats ? '0 : len_q;
  assign keep_base = clr_stats ? '0 : keep_q;
  assign pkt_sum   = {1'b0, pkt_base} + 33'd1;
  assign byte_sum  = {1'b0, byte_base} + 49'(acc_new);
  assign len_sum   = {1'b0, len_base} + 17'd1;
  assign keep_sum  = {1'b0, keep_base} + 17'd1;

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    acc_d        = acc_q;
    done_d       = 1'b0;
    done_bytes_d = done_bytes_q;
    pkt_d        = pkt_base;
    byte_d       = byte_base;
    len_d        = len_base;
    keep_d       = keep_base;
    sticky_d     = clr_stats ? 4'b0 : sticky_q;
    if (push) begin
      if (!keep_ok) begin
        keep_d      = keep_sum[16] ? 16'hFFFF : keep_sum[15:0];
        sticky_d[1] = 1'b1;
      end
      if (state_q == IN_PKT && s_axis_tuser_size != size_q) sticky_d[2] = 1'b1;
      if (32'(acc_new) > MAX_PKT_BYTES) sticky_d[3] = 1'b1;
      if (state_q == IDLE) size_d = s_axis_tuser_size;
      acc_d = acc_new;
      if (s_axis_tlast) begin
        state_d      = IDLE;
        done_d       = 1'b1;
        done_bytes_d = acc_new[AW-1] ? {USER_SIZE_WIDTH{1'b1}} : acc_new[USER_SIZE_WIDTH-1:0];
        pkt_d        = pkt_sum[32] ? '1 : pkt_sum[31:0];
        byte_d       = byte_sum[48] ? '1 : byte_sum[47:0];
        if (acc_new != {1'b0, size_cmp}) begin
          len_d       = len_sum[16] ? 16'hFFFF : len_sum[15:0];
          sticky_d[0] = 1'b1;
        end
      end else begin
        state_d = IN_PKT;
      end
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      ent0_q       <= '0;
      ent1_q       <= '0;
      cnt_q        <= 2'd0;
      rdy_q        <= 1'b0;
      state_q      <= IDLE;
      size_q       <= '0;
      acc_q        <= '0;
      done_q       <= 1'b0;
      done_bytes_q <= '0;
      pkt_q        <= '0;
      byte_q       <= '0;
      len_q        <= '0;
      keep_q       <= '0;
      sticky_q     <= '0;
    end else begin
      ent0_q       <= ent0_d;
      ent1_q       <= ent1_d;
      cnt_q        <= cnt_d;
      rdy_q        <= rdy_d;
      state_q      <= state_d;
      size_q       <= size_d;
      acc_q        <= acc_d;
      done_q       <= done_d;
      done_bytes_q <= done_bytes_d;
      pkt_q        <= pkt_d;
      byte_q       <= byte_d;
      len_q        <= len_d;
      keep_q       <= keep_d;
      sticky_q     <= sticky_d;
    end
  end

  assign s_axis_tready     = rdy_q;
  assign m_axis_tvalid     = (cnt_q != 2'd0);
  assign m_axis_tdata      = ent0_q.data;
  assign m_axis_tkeep      = ent0_q.keep;
  assign m_axis_tlast      = ent0_q.last;
  assign m_axis_tuser_size = ent0_q.user;
  assign pkt_done          = done_q;
  assign pkt_done_bytes    = done_bytes_q;
  assign stat_pkt_cnt      = pkt_q;
  assign stat_byte_cnt     = byte_q;
  assign stat_len_err_cnt  = len_q;
  assign stat_keep_err_cnt = keep_q;
  assign err_sticky        = sticky_q;
endmodule
